// File: rtl/hack_fetch_pkg.sv
// hack_fetch_pkg: shared widths, reset address and fetch FSM states for hack_fetch
package hack_fetch_pkg;
  localparam int HACK_ADDR_W = 15;
  localparam int HACK_DATA_W = 16;
  localparam int HACK_RESET_PC = 0;
  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;
endpackage

// File: rtl/hack_fetch_counter.sv
// hack_fetch_counter: 32-bit enable-gated wrapping counter with async reset
module hack_fetch_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);
  // count enabled cycles, wrapping on overflow
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (en) count <= count + 32'd1;
endmodule

// File: rtl/hack_fetch.sv
// hack_fetch: Hack CPU fetch stage (PC, ROM address, valid/ready); HACK_FETCH_PERF_EN adds perf counters
module hack_fetch
  import hack_fetch_pkg::*;
#(
  parameter int ADDR_W   = HACK_ADDR_W,
  parameter int DATA_W   = HACK_DATA_W,
  parameter int RESET_PC = HACK_RESET_PC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target
`ifdef HACK_FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  state_t state;
  logic [ADDR_W-1:0] fetch_pc, pend_pc;
  logic pend_valid;
  assign inst = rom_data;
  assign inst_pc = pend_pc;
  assign inst_valid = pend_valid;
  // jump wins; a held word is re-read so rom_data stays stable under back-pressure
  assign rom_address = jump ? jump_target : (pend_valid && !inst_ready) ? pend_pc : fetch_pc;
  // fetch FSM: boot, stream one word per cycle, hold while the core stalls
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= BOOT;
      pend_valid <= 1'b0;
      pend_pc <= RST_PC;
      fetch_pc <= RST_PC;
    end else if (jump) begin
      state <= RUN;
      pend_valid <= 1'b1;
      pend_pc <= jump_target;
      fetch_pc <= jump_target + 1'b1;
    end else case (state)
      BOOT:
        if (fetch_en) begin
          state <= RUN;
          pend_valid <= 1'b1;
          pend_pc <= fetch_pc;
          fetch_pc <= fetch_pc + 1'b1;
        end
      RUN, STALL:
        if (pend_valid && !inst_ready) state <= STALL;
        else begin
          state <= RUN;
          pend_valid <= fetch_en;
          if (fetch_en) begin
            pend_pc <= fetch_pc;
            fetch_pc <= fetch_pc + 1'b1;
          end
        end
      default: state <= BOOT;
    endcase
`ifdef HACK_FETCH_PERF_EN
  hack_fetch_counter u_fetch_count (
    .clock(clock), .reset(reset), .en(pend_valid && inst_ready && !jump), .count(fetch_count)
  );
  hack_fetch_counter u_stall_count (
    .clock(clock), .reset(reset), .en(pend_valid && !inst_ready), .count(stall_count)
  );
`endif
endmodule

// File: doc/hack_fetch.md
# hack_fetch

Instruction-fetch stage sitting between the Hack CPU core and the 32K-word instruction ROM. It owns the program counter, drives the ROM address, absorbs the ROM's one-cycle synchronous read latency, and hands instructions to the core over a valid/ready handshake. Jumps redirect fetch with zero bubbles, and downstream back-pressure holds the presented instruction stable.

## Interface
- ADDR_W, 15: instruction address width (32K words).
- DATA_W, 16: instruction width.
- RESET_PC, 0: first address fetched after reset.

- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_en  in  1  when low, no new fetch is started; the instruction already in flight is still delivered.
- rom_address  out  ADDR_W  address to the ROM; combinational from state and inputs.
- rom_data  in  DATA_W  ROM output, valid one cycle after its address was sampled.
- inst  out  DATA_W  instruction to the core; equals rom_data.
- inst_pc  out  ADDR_W  address of inst.
- inst_valid  out  1  inst/inst_pc hold a live instruction.
- inst_ready  in  1  the core accepts inst this cycle when inst_valid=1.
- jump  in  1  redirect request; single-cycle.
- jump_target  in  ADDR_W  redirect address, sampled when jump=1.

## Operation
- State registers:
  - fetch_pc: next address to fetch.
  - pend_pc: address whose data is currently on rom_data.
  - pend_valid: rom_data holds a live instruction.
  - FSM state: BOOT, RUN, or STALL.
- Outputs: inst_valid = pend_valid; inst_pc = pend_pc; inst = rom_data.
- Address mux, in priority order:
  1. jump=1 → jump_target.
  2. pend_valid=1 and inst_ready=0 → pend_pc, so the ROM re-reads the held word.
  3. Otherwise → fetch_pc.
- FSM states and transitions:
  - BOOT: entered on reset. On the first edge after release with fetch_en=1 → RUN, pend_valid←1, pend_pc←fetch_pc, fetch_pc←fetch_pc+1.
  - RUN: on each edge where inst_ready=1 or pend_valid=0:
    - fetch_en=1 → issue the next fetch (same update as above).
    - fetch_en=0 → pend_valid←0 and stay in RUN; fetch resumes when fetch_en returns high.
  - RUN → STALL when pend_valid=1 and inst_ready=0. All registers hold.
  - STALL → RUN on inst_ready=1, issuing per fetch_en.
- Jump, from any state except reset:
  - pend_pc←jump_target, fetch_pc←jump_target+1, pend_valid←1 (regardless of fetch_en); next state RUN.
  - The instruction presented in the jump cycle is squashed. Whether it also counts as accepted is decided by the core's inst_ready, not by this block.
- Arithmetic: fetch_pc increments modulo 2^ADDR_W, so 32767 is followed by 0 with no error.

## Timing
- Reset values: inst_valid=0, inst_pc=RESET_PC, rom_address=RESET_PC, fetch_pc=RESET_PC+1 is not applied (fetch_pc=RESET_PC), state BOOT. inst is not reset; it follows rom_data.
- Latency:
  - reset release → first inst_valid=1: one edge.
  - jump → inst=mem[jump_target]: one edge.
- Throughput: one instruction per cycle while inst_ready=1.
- Handshake:
  - Once inst_valid=1, inst and inst_pc stay stable until an edge with inst_ready=1 or jump=1.
  - inst_valid never drops without acceptance, except on jump or reset.
- Simultaneous events:
  - jump beats stall, and jump beats fetch_en=0.
  - jump together with inst_ready=1 behaves as a normal jump.
- Reset mid-stall or mid-jump: all state clears immediately, asynchronously.

## Configuration
- HACK_FETCH_PERF_EN defined:
  - Adds output fetch_count (32 bits): increments on each accepted instruction (inst_valid & inst_ready & !jump).
  - Adds output stall_count (32 bits): increments on each cycle with inst_valid & !inst_ready.
  - Both reset to 0 and wrap on overflow.
- HACK_FETCH_PERF_EN undefined: neither port nor any counter logic exists. Fetch behaviour is identical either way.

## Structure
- Package hack_fetch_pkg holds:
  - the ADDR_W/DATA_W defaults;
  - RESET_PC;
  - the state enum (BOOT, RUN, STALL).
- Sub-module hack_fetch_counter is a 32-bit enable-gated, async-reset counter. It is instantiated twice, and only under HACK_FETCH_PERF_EN.

## Test plan
- Reset, then release with fetch_en=1 and inst_ready=1 against ROM words 0..3 → inst_pc 0,1,2,3 on consecutive cycles; inst matches the ROM contents.
- Hold inst_ready=0 for 3 cycles at inst_pc=5 → inst_pc=5 and inst stay stable and rom_address=5; after release, inst_pc=6 on the next cycle.
- Assert jump with jump_target=16 while stalled at pc 9 → next cycle inst_pc=16 with inst=mem[16], then 17.
- Start fetch at 32766 via jump → inst_pc 32766, 32767, 0.
- Drop fetch_en at pc 3 while ready → pc 3 delivered, then inst_valid=0; raise fetch_en → pc 4 appears one cycle later.
- With HACK_FETCH_PERF_EN: 10 accepted instructions plus 4 stall cycles → fetch_count=10, stall_count=4. Assert reset mid-stream → both counters, inst_valid and state clear immediately.
